// File: rtl/io_pkg.sv
// io_pkg: shared constants for the BRAM <-> UART io path.
// Holds the default bit time, the UART idle level and the state encodings
// used by bram_uart_sender and uart_tx_byte.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state encoding).
package io_pkg;

  // 100 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  // Level of an idle UART line (also the stop bit level)
  localparam logic UART_IDLE = 1'b1;

  // Word sequencer states (top level)
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_FRAME   = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Byte serialiser states (uart_tx_byte)
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] TX_PARITY = 3'd3;
`endif
  localparam logic [2:0] TX_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: serialises one byte as a UART frame on a registered tx line.
// Frame is start bit, 8 data bits LSB first, optional even parity, stop bit.
// A one-cycle load in idle captures the byte; frame_done is high during the
// last cycle of the stop bit so the sequencer can react without a lost cycle.
// Optional feature macro: UART_TX_PARITY_EN (8E1 frames instead of 8N1).
module uart_tx_byte
  import io_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data_byte,
  output logic       tx,
  output logic       frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [2:0]        state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              parity;
`endif

  // A bit period ends on the last count of the baud counter
  assign bit_end    = (baud == BAUD_LAST);
  assign frame_done = (state == TX_STOP) && bit_end;

  // Frame sequencing: baud counter wraps each bit, tx always comes from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= UART_IDLE;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        TX_IDLE: begin
          baud    <= '0;
          bit_cnt <= '0;
          if (load) begin
            shreg  <= data_byte;
`ifdef UART_TX_PARITY_EN
            parity <= ^data_byte;
`endif
            tx     <= 1'b0;
            state  <= TX_START;
          end
        end

        TX_START: begin
          if (bit_end) begin
            baud  <= '0;
            tx    <= shreg[0];
            state <= TX_DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        TX_DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= parity;
              state   <= TX_PARITY;
`else
              tx      <= UART_IDLE;
              state   <= TX_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (bit_end) begin
            baud  <= '0;
            tx    <= UART_IDLE;
            state <= TX_STOP;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`endif

        TX_STOP: begin
          if (bit_end) begin
            baud  <= '0;
            state <= TX_IDLE;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        default: begin
          baud  <= '0;
          tx    <= UART_IDLE;
          state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/bram_uart_sender.sv
// bram_uart_sender: on a rising send command, reads WORD_COUNT words from
// block RAM starting at START_ADDR and sends the low byte of each one as a
// UART frame. Owns the command edge detector, address/word counters and the
// word sequencing; bit timing lives in uart_tx_byte.
// Between frames tx stays idle for exactly the NEXT, RD_WAIT and LOAD cycles.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit per frame).
module bram_uart_sender
  import io_pkg::*;
#(
  parameter int                CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] START_ADDR   = '0,
  parameter int                WORD_COUNT   = 4
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              ctrl_io_send,
  input  logic [15:0]       data_in_io,
  output logic [ADDR_W-1:0] addr_io,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              led_tx
);

  localparam int WC_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WORD_COUNT - 1);

  logic            send_cur;
  logic            send_prev;
  logic            start;
  logic [2:0]      state;
  logic [WC_W-1:0] word_cnt;
  logic            load;
  logic            frame_done;
  logic            unused_data_hi;

  // Only the low byte of each RAM word is transmitted
  assign unused_data_hi = ^data_in_io[15:8];

  // Register the send command and keep its previous value for edge detection
  always_ff @(posedge clk_100) begin
    if (rst) begin
      send_cur  <= 1'b0;
      send_prev <= 1'b0;
    end else begin
      send_cur  <= ctrl_io_send;
      send_prev <= send_cur;
    end
  end

  // A transfer is requested only on a 0->1 transition of the command
  assign start  = send_cur & ~send_prev;
  assign load   = (state == S_LOAD);
  assign led_tx = busy;

  // Word sequencer: fetch, hand byte to serialiser, wait for frame, advance
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_io  <= START_ADDR;
      word_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_io  <= START_ADDR;
            word_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: state <= S_LOAD;

        S_LOAD: state <= S_FRAME;

        S_FRAME: begin
          if (frame_done) begin
            state <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (word_cnt == WORD_LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            word_cnt <= word_cnt + WC_W'(1);
            addr_io  <= addr_io + ADDR_W'(1);
            state    <= S_RD_WAIT;
          end
        end

        S_DONE: state <= S_IDLE;

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk_100),
    .rst       (rst),
    .load      (load),
    .data_byte (data_in_io[7:0]),
    .tx        (tx),
    .frame_done(frame_done)
  );

endmodule

// File: tb/tb_bram_uart_sender.sv
// tb_bram_uart_sender: directed bench for bram_uart_sender with a registered
// BRAM model and a behavioural UART sampler that reads tx at mid-bit.
// The bit time is shortened to 100 clocks so every scenario fits a short run;
// all timing expectations are expressed in units of that bit time.
// Optional feature macro: UART_TX_PARITY_EN (expects 8E1 frames).
module tb_bram_uart_sender;

  localparam int CPB = 100;
  localparam int AW  = 16;
  localparam int WC  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_PITCH = FRAME_BITS * CPB + 3;

  logic          clk_100 = 1'b0;
  logic          rst = 1'b1;
  logic          ctrl_io_send = 1'b0;
  logic [15:0]   data_in_io = '0;
  logic [AW-1:0] addr_io;
  logic          tx;
  logic          busy;
  logic          done;
  logic          led_tx;

  logic [15:0]   mem [0:15];
  int            cyc = 0;
  int            vectors = 0;
  int            errors = 0;

  logic [7:0]    rxQ[$];
  int            addrQ[$];
  logic          stopQ[$];
  int            startQ[$];
  int            riseQ[$];
`ifdef UART_TX_PARITY_EN
  logic          parQ[$];
`endif
  int            doneCount = 0;
  logic          txPrev = 1'b1;

  logic [7:0]    expByte [0:3];
  logic          expPar  [0:3];

  bram_uart_sender #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .START_ADDR  (16'h0000),
    .WORD_COUNT  (WC)
  ) dut (
    .clk_100     (clk_100),
    .rst         (rst),
    .ctrl_io_send(ctrl_io_send),
    .data_in_io  (data_in_io),
    .addr_io     (addr_io),
    .tx          (tx),
    .busy        (busy),
    .done        (done),
    .led_tx      (led_tx)
  );

  always #5 clk_100 = ~clk_100;

  // Cycle counter used to timestamp tx activity
  always @(posedge clk_100) cyc <= cyc + 1;

  // BRAM port A: data appears one cycle after the address
  always @(posedge clk_100) data_in_io <= mem[addr_io[3:0]];

  // Log tx rising edges and done cycles away from the active edge
  always @(negedge clk_100) begin
    if (txPrev === 1'b0 && tx === 1'b1) riseQ.push_back(cyc);
    txPrev = tx;
    if (done === 1'b1) doneCount++;
  end

  task automatic skipCycles(input int n, inout bit aborted);
    repeat (n) begin
      @(negedge clk_100);
      if (rst === 1'b1) aborted = 1'b1;
    end
  endtask

  // Behavioural UART receiver sampling each bit in its middle
  initial begin : sampler
    int            t0;
    logic [AW-1:0] a0;
    logic [7:0]    b;
    logic          s;
    bit            ab;
`ifdef UART_TX_PARITY_EN
    logic          p;
`endif
    forever begin
      @(negedge clk_100);
      if (rst === 1'b0 && tx === 1'b0) begin
        t0 = cyc;
        a0 = addr_io;
        ab = 1'b0;
        b  = '0;
        startQ.push_back(t0);
        skipCycles(CPB / 2, ab);
        if (tx !== 1'b0) ab = 1'b1;
        for (int i = 0; i < 8; i++) begin
          skipCycles(CPB, ab);
          b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        skipCycles(CPB, ab);
        p = tx;
`endif
        skipCycles(CPB, ab);
        s = tx;
        if (!ab) begin
          rxQ.push_back(b);
          addrQ.push_back(int'(a0));
          stopQ.push_back(s);
`ifdef UART_TX_PARITY_EN
          parQ.push_back(p);
`endif
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic send, input int n);
    @(negedge clk_100);
    rst          = r;
    ctrl_io_send = send;
    repeat (n) @(negedge clk_100);
  endtask

  task automatic waitStarts(input int target, input int budget);
    int k = 0;
    while (startQ.size() < target && k < budget) begin
      @(negedge clk_100);
      k++;
    end
    checkOutput("frame start count", startQ.size(), target);
  endtask

  task automatic waitRx(input int target, input int budget);
    int k = 0;
    while (rxQ.size() < target && k < budget) begin
      @(negedge clk_100);
      k++;
    end
    checkOutput("received frame count", rxQ.size(), target);
  endtask

  function automatic int firstRiseAfter(input int t);
    foreach (riseQ[i]) if (riseQ[i] > t) return riseQ[i];
    return -1;
  endfunction

  task automatic checkTransfer(input int base);
    if (rxQ.size() < base + WC) return;
    for (int i = 0; i < WC; i++) begin
      checkOutput($sformatf("byte %0d", i), rxQ[base+i], expByte[i]);
      checkOutput($sformatf("addr %0d", i), addrQ[base+i], i);
      checkOutput($sformatf("stop %0d", i), stopQ[base+i], 1);
`ifdef UART_TX_PARITY_EN
      checkOutput($sformatf("parity %0d", i), parQ[base+i], expPar[i]);
`endif
    end
  endtask

  initial begin : main
    int sBase, rBase, dBase, raiseCyc, fs, bad, guard;

    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0] = 16'h001E;
    mem[1] = 16'h00E0;
    mem[2] = 16'h00AA;
    mem[3] = 16'h00AA;
    expByte[0] = 8'h1E; expPar[0] = 1'b0;
    expByte[1] = 8'hE0; expPar[1] = 1'b1;
    expByte[2] = 8'hAA; expPar[2] = 1'b0;
    expByte[3] = 8'hAA; expPar[3] = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("reset tx", tx, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset addr", addr_io, 0);
    checkOutput("reset led_tx", led_tx, 0);

    $display("[TB] transfer");
    sBase = startQ.size();
    rBase = rxQ.size();
    dBase = doneCount;
    applyStimulus(1'b0, 1'b1, 0);
    raiseCyc = cyc;
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("busy during transfer", busy, 1);
    checkOutput("led_tx during transfer", led_tx, 1);
    waitStarts(sBase + 1, 20);
    if (startQ.size() > sBase)
      checkOutput("start latency", startQ[sBase] - (raiseCyc + 1), 3);
    waitStarts(sBase + 2, FRAME_PITCH + 20);
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 0);
    waitRx(rBase + WC, (WC + 1) * FRAME_PITCH);
    applyStimulus(1'b0, 1'b1, CPB);
    checkOutput("done pulses", doneCount - dBase, 1);
    checkOutput("busy after done", busy, 0);
    checkOutput("led_tx after done", led_tx, 0);
    checkOutput("final addr", addr_io, WC - 1);
    checkTransfer(rBase);
    if (startQ.size() >= sBase + WC) begin
      checkOutput("frame pitch 0-1", startQ[sBase+1] - startQ[sBase], FRAME_PITCH);
      checkOutput("frame pitch 2-3", startQ[sBase+3] - startQ[sBase+2], FRAME_PITCH);
      checkOutput("low run 0x1E", firstRiseAfter(startQ[sBase]) - startQ[sBase], 2 * CPB);
      checkOutput("low run 0xE0", firstRiseAfter(startQ[sBase+1]) - startQ[sBase+1], 6 * CPB);
    end

    $display("[TB] level hold");
    sBase = startQ.size();
    bad = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_100);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checkOutput("hold idle violations", bad, 0);
    checkOutput("hold frame starts", startQ.size(), sBase);
    checkOutput("hold addr", addr_io, WC - 1);

    $display("[TB] retransmit");
    mem[2] = 16'hFFAA;
    applyStimulus(1'b0, 1'b0, 3);
    rBase = rxQ.size();
    dBase = doneCount;
    applyStimulus(1'b0, 1'b1, 0);
    waitRx(rBase + WC, (WC + 1) * FRAME_PITCH);
    applyStimulus(1'b0, 1'b1, CPB);
    checkTransfer(rBase);
    checkOutput("retransmit done pulses", doneCount - dBase, 1);

    $display("[TB] abort");
    applyStimulus(1'b0, 1'b0, 3);
    sBase = startQ.size();
    rBase = rxQ.size();
    applyStimulus(1'b0, 1'b1, 0);
    waitStarts(sBase + 2, 2 * FRAME_PITCH + 20);
    if (startQ.size() >= sBase + 2) begin
      fs = startQ[sBase+1];
      guard = 0;
      while (cyc < fs + 5 * CPB + CPB / 2 && guard < 2 * FRAME_PITCH) begin
        @(negedge clk_100);
        guard++;
      end
      rst = 1'b1;
      ctrl_io_send = 1'b0;
      @(negedge clk_100);
      checkOutput("abort tx", tx, 1);
      checkOutput("abort busy", busy, 0);
      checkOutput("abort addr", addr_io, 0);
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 9 * CPB);
      checkOutput("abort rx count", rxQ.size(), rBase + 1);
      checkOutput("abort no restart", startQ.size(), sBase + 2);
    end
    rBase = rxQ.size();
    dBase = doneCount;
    applyStimulus(1'b0, 1'b1, 0);
    waitRx(rBase + WC, (WC + 1) * FRAME_PITCH);
    applyStimulus(1'b0, 1'b1, CPB);
    checkTransfer(rBase);
    checkOutput("post-abort done pulses", doneCount - dBase, 1);

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity bytes");
    mem[0] = 16'h00AA;
    mem[1] = 16'h0001;
    expByte[0] = 8'hAA; expPar[0] = 1'b0;
    expByte[1] = 8'h01; expPar[1] = 1'b1;
    applyStimulus(1'b0, 1'b0, 3);
    sBase = startQ.size();
    rBase = rxQ.size();
    applyStimulus(1'b0, 1'b1, 0);
    waitRx(rBase + WC, (WC + 1) * FRAME_PITCH);
    applyStimulus(1'b0, 1'b1, CPB);
    checkTransfer(rBase);
    if (startQ.size() >= sBase + 2)
      checkOutput("parity frame pitch", startQ[sBase+1] - startQ[sBase], 11 * CPB + 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
